bus_ram: RTL and testbench

- Word-organised data memory slave on the generated-core data bus: addr/size/valid/write/wdata in, rdata/ready out.
- Sits directly downstream of every C-to-HDL generated processor FSM and serves its stack and heap loads and stores.
- Returns the aligned 32-bit word that contains the address. The master does the lane shift itself (rdata >> 8*addr[1:0]).
- Takes right-justified store data and places it into the addressed byte lanes.

---
 rtl/bus_ram.sv | 138 +++++++++++++
 tb/tb_bus_ram.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram.sv
// Word-organised data memory slave for the generated-core data bus.
// Loads return the aligned containing word; stores merge right-justified data into byte lanes.
module bus_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int LAT   = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid,
   input  logic          write,
   input  logic [2:0]    size,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          ready,
   output logic          err,
   output logic          busy,
   input  logic          init_we,
   input  logic [AW-1:0] init_addr,
   input  logic [31:0]   init_wdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [3:0] LAT_LOAD = 4'((LAT > 0) ? LAT - 1 : 0);

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          req_write;
   logic [2:0]    req_size;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          enter_resp;
   logic          cur_write;
   logic [2:0]    cur_size;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [AW-1:0] idx;
   logic          bad;
   logic [3:0]    lanes;
   logic [31:0]   placed;
   logic [31:0]   merged;

   assign accept     = (state == IDLE) && valid && !init_we;
   assign enter_resp = (accept && (LAT == 0)) || ((state == WAIT) && (cnt == 4'd0));
   assign ready      = (state == RESP);
   assign busy       = (state != IDLE);

   // With no wait states the access completes on the accepting edge, so the live bus is used.
   assign cur_write = (state == IDLE) ? write : req_write;
   assign cur_size  = (state == IDLE) ? size  : req_size;
   assign cur_addr  = (state == IDLE) ? addr  : req_addr;
   assign cur_wdata = (state == IDLE) ? wdata : req_wdata;
   assign idx       = cur_addr[AW+1:2];

   always_comb begin
      bad    = 1'b0;
      lanes  = 4'b0000;
      placed = 32'h0;
      case (cur_size)
         3'd0: begin
            lanes  = 4'b0001 << cur_addr[1:0];
            placed = {4{cur_wdata[7:0]}};
         end
         3'd1: begin
            bad    = cur_addr[0];
            lanes  = cur_addr[1] ? 4'b1100 : 4'b0011;
            placed = {2{cur_wdata[15:0]}};
         end
         3'd2: begin
            bad    = |cur_addr[1:0];
            lanes  = 4'b1111;
            placed = cur_wdata;
         end
         default: bad = 1'b1;
      endcase
      if ((cur_addr >> (AW + 2)) != 32'h0)
         bad = 1'b1;
      merged = mem[idx];
      for (int i = 0; i < 4; i++)
         if (lanes[i])
            merged[8*i +: 8] = placed[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state == IDLE) && init_we)
            mem[init_addr] <= init_wdata;
         else if (enter_resp && cur_write && !bad)
            mem[idx] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rdata     <= 32'h0;
         err       <= 1'b0;
         req_write <= 1'b0;
         req_size  <= 3'd0;
         req_addr  <= 32'h0;
         req_wdata <= 32'h0;
      end else begin
         err <= enter_resp && bad;
         if (enter_resp)
            rdata <= bad ? 32'h0 : (cur_write ? merged : mem[idx]);
         if (accept) begin
            req_write <= write;
            req_size  <= size;
            req_addr  <= addr;
            req_wdata <= wdata;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= (LAT == 0) ? RESP : WAIT;
                  cnt   <= LAT_LOAD;
               end
            end
            WAIT: begin
               if (cnt == 4'd0)
                  state <= RESP;
               else
                  cnt <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_ram.sv
// Scoreboard bench for bus_ram: instance 0 has no wait states, instance 1 has three.
module tb_bus_ram;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        valid [2];
   logic        write [2];
   logic [2:0]  size [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        err [2];
   logic        busy [2];
   logic        init_we [2];
   logic [7:0]  init_addr [2];
   logic [31:0] init_wdata [2];

   logic [31:0] model [2][256];
   exp_t        q0[$];
   exp_t        q1[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   bus_ram #(.DEPTH(256), .AW(8), .LAT(0)) dut0 (
      .clk(clk), .rst(rst[0]), .valid(valid[0]), .write(write[0]), .size(size[0]),
      .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]),
      .busy(busy[0]), .init_we(init_we[0]), .init_addr(init_addr[0]), .init_wdata(init_wdata[0]));

   bus_ram #(.DEPTH(256), .AW(8), .LAT(3)) dut1 (
      .clk(clk), .rst(rst[1]), .valid(valid[1]), .write(write[1]), .size(size[1]),
      .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]),
      .busy(busy[1]), .init_we(init_we[1]), .init_addr(init_addr[1]), .init_wdata(init_wdata[1]));

   always #5 clk = ~clk;

   // Edge counter used to timestamp both requests and responses.
   always @(posedge clk) cyc = cyc + 1;

   function automatic int latOf(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic int qSize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference behaviour from the access rules: legality, lane merge, aligned word returned.
   task automatic modelAccess(input int d, input logic wr, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd, output exp_t e);
      logic        bad;
      logic [31:0] w;
      int          wi;
      bad = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (a >= 32'd1024);
      wi  = int'(a[9:2]);
      e.cyc = 0;
      if (bad) begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end else begin
         w = model[d][wi];
         if (wr) begin
            if (sz == 3'd0)      w[8*a[1:0] +: 8] = wd[7:0];
            else if (sz == 3'd1) w[16*a[1] +: 16] = wd[15:0];
            else                 w = wd;
            model[d][wi] = w;
         end
         e.rdata = w;
         e.err   = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int d, input logic wr, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input bit expect_resp);
      exp_t e;
      @(posedge clk); #1;
      valid[d] = 1'b1; write[d] = wr; size[d] = sz; addr[d] = a; wdata[d] = wd;
      if (expect_resp) begin
         modelAccess(d, wr, sz, a, wd, e);
         e.cyc = cyc + 1 + latOf(d);
         if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(posedge clk); #1;
      valid[d] = 1'b0;
   endtask

   task automatic waitDone(input int d);
      int n = 0;
      while (qSize(d) != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (qSize(d) != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout dut%0d: got %0d pending expected 0", d, qSize(d));
         if (d == 0) q0.delete(); else q1.delete();
      end
   endtask

   task automatic initWrite(input int d, input logic [7:0] ia, input logic [31:0] data);
      @(posedge clk); #1;
      init_we[d] = 1'b1; init_addr[d] = ia; init_wdata[d] = data;
      model[d][ia] = data;
      @(posedge clk); #1;
      init_we[d] = 1'b0;
   endtask

   // Monitor: every response is popped and compared against the scoreboard.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         exp_t e;
         if (ready[d] === 1'b1) begin
            if (qSize(d) == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ready dut%0d: got ready=1 expected 0 (t=%0t)", d, $time);
            end else begin
               if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
               checkOutput($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
               checkOutput($sformatf("err_dut%0d", d), {31'h0, err[d]}, {31'h0, e.err});
               checkOutput($sformatf("latency_dut%0d", d), cyc, e.cyc);
               checkOutput($sformatf("busy_at_ready_dut%0d", d), {31'h0, busy[d]}, 32'h1);
            end
         end else if (err[d] !== 1'b0) begin
            checkOutput($sformatf("err_without_ready_dut%0d", d), {31'h0, err[d]}, 32'h0);
         end
      end
   end

   initial begin
      int n0;
      logic [31:0] a;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; valid[d] = 1'b0; write[d] = 1'b0; size[d] = 3'd0;
         addr[d] = 32'h0; wdata[d] = 32'h0;
         init_we[d] = 1'b0; init_addr[d] = 8'h0; init_wdata[d] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("reset_ready_dut%0d", d), {31'h0, ready[d]}, 32'h0);
         checkOutput($sformatf("reset_err_dut%0d", d), {31'h0, err[d]}, 32'h0);
         checkOutput($sformatf("reset_busy_dut%0d", d), {31'h0, busy[d]}, 32'h0);
         checkOutput($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
      end

      // Preload both memories so no load ever reads an unwritten word.
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            init_we[d] = 1'b1; init_addr[d] = 8'(i); init_wdata[d] = $urandom;
            model[d][i] = init_wdata[d];
         end
      end
      @(posedge clk); #1;
      init_we[0] = 1'b0; init_we[1] = 1'b0;

      // Zero wait states: word store/load, byte and half merges, error cases.
      applyStimulus(0, 1'b1, 3'd2, 32'h24, 32'h12345678, 1'b1); waitDone(0);
      applyStimulus(0, 1'b0, 3'd2, 32'h24, 32'h0, 1'b1);        waitDone(0);
      initWrite(0, 8'd9, 32'h0);
      applyStimulus(0, 1'b1, 3'd0, 32'h25, 32'h000000AB, 1'b1); waitDone(0);
      applyStimulus(0, 1'b0, 3'd2, 32'h24, 32'h0, 1'b1);        waitDone(0);
      checkOutput("byte_merge_word", rdata[0], 32'h0000AB00);
      applyStimulus(0, 1'b1, 3'd1, 32'h26, 32'h0000BEEF, 1'b1); waitDone(0);
      checkOutput("half_merge_word", rdata[0], 32'hBEEFAB00);
      applyStimulus(0, 1'b1, 3'd1, 32'h23, 32'hFFFFFFFF, 1'b1); waitDone(0);
      applyStimulus(0, 1'b1, 3'd3, 32'h20, 32'hFFFFFFFF, 1'b1); waitDone(0);
      applyStimulus(0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1);        waitDone(0);
      applyStimulus(0, 1'b0, 3'd2, 32'h400, 32'h0, 1'b1);       waitDone(0);
      checkOutput("out_of_range_rdata", rdata[0], 32'h0);

      // Init write and bus request in the same cycle: only the init write happens.
      @(posedge clk); #1;
      init_we[0] = 1'b1; init_addr[0] = 8'd5; init_wdata[0] = 32'h5555AAAA;
      valid[0] = 1'b1; write[0] = 1'b1; size[0] = 3'd2; addr[0] = 32'h14; wdata[0] = 32'h77777777;
      model[0][5] = 32'h5555AAAA;
      @(posedge clk); #1;
      init_we[0] = 1'b0; valid[0] = 1'b0;
      repeat (5) @(posedge clk);
      applyStimulus(0, 1'b0, 3'd2, 32'h14, 32'h0, 1'b1);        waitDone(0);

      // Three wait states: a re-pulsed valid during the wait is ignored.
      @(posedge clk); #1;
      valid[1] = 1'b1; write[1] = 1'b1; size[1] = 3'd2; addr[1] = 32'h30; wdata[1] = 32'hCAFEF00D;
      begin
         exp_t e;
         modelAccess(1, 1'b1, 3'd2, 32'h30, 32'hCAFEF00D, e);
         e.cyc = cyc + 1 + 3;
         q1.push_back(e);
      end
      @(posedge clk); #1;
      valid[1] = 1'b0;
      @(negedge clk); checkOutput("busy_wait_c1", {31'h0, busy[1]}, 32'h1);
      @(posedge clk); #1;
      valid[1] = 1'b1; write[1] = 1'b1; size[1] = 3'd2; addr[1] = 32'h34; wdata[1] = 32'h11111111;
      @(negedge clk); checkOutput("busy_wait_c2", {31'h0, busy[1]}, 32'h1);
      @(posedge clk); #1;
      valid[1] = 1'b0;
      @(negedge clk); checkOutput("busy_wait_c3", {31'h0, busy[1]}, 32'h1);
      @(posedge clk);
      @(negedge clk); checkOutput("busy_resp_c4", {31'h0, busy[1]}, 32'h1);
      @(posedge clk);
      @(negedge clk); checkOutput("busy_after_resp", {31'h0, busy[1]}, 32'h0);
      waitDone(1);
      applyStimulus(1, 1'b0, 3'd2, 32'h34, 32'h0, 1'b1);        waitDone(1);
      applyStimulus(1, 1'b0, 3'd2, 32'h30, 32'h0, 1'b1);        waitDone(1);

      // Reset during the wait abandons an uncommitted store.
      applyStimulus(1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
      @(posedge clk); #1;
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_ready", {31'h0, ready[1]}, 32'h0);
      checkOutput("rst_mid_err", {31'h0, err[1]}, 32'h0);
      checkOutput("rst_mid_busy", {31'h0, busy[1]}, 32'h0);
      repeat (4) @(posedge clk);
      applyStimulus(1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);        waitDone(1);

      // Randomized traffic against the reference model on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 60; k++) begin
            n0 = $urandom_range(0, 7);
            a  = (n0 == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 1023));
            applyStimulus(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), a, $urandom, 1'b1);
            waitDone(d);
         end
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
